// File: rtl/hps_pio_word_receiver_pkg.sv
// Shared bit positions for the HPS PIO command word and the returned status word.
package hps_pio_word_receiver_pkg;
  localparam int PIO_TOG_BIT    = 31;
  localparam int PIO_LAST_BIT   = 30;
  localparam int PIO_OVFCLR_BIT = 29;
  localparam int ST_ACK_BIT     = 31;
  localparam int ST_OVF_BIT     = 30;
  localparam int ST_VALID_BIT   = 29;
  localparam int ST_LEVEL_LSB   = 0;
  localparam int ST_LEVEL_W     = 8;
  localparam int MAX_DEPTH      = 128;
endpackage

// File: rtl/hps_rx_fifo.sv
// Synchronous FIFO with level counter and a registered first-word fall-through head.
module hps_rx_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic [LVL_W-1:0] level,
  output logic             not_empty
);
  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [W-1:0]     head_q;

  assign rd_nxt    = rd_ptr + PTR_W'(1);
  assign rdata     = head_q;
  assign not_empty = (level != '0);

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      head_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_nxt;
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      // Head register always mirrors the oldest stored word so the output is
      // registered yet has no bubble after a pop or a push into an empty FIFO.
      if (pop) begin
        if (level > LVL_W'(1)) head_q <= mem[rd_nxt];
        else if (push)         head_q <= wdata;
      end else if (push && level == '0) begin
        head_q <= wdata;
      end
    end
  end
endmodule

// File: rtl/hps_pio_word_receiver.sv
// Converts toggle-handshaked HPS PIO writes into a valid/ready stream with an
// ack/overflow status word returned to the HPS.
module hps_pio_word_receiver
  import hps_pio_word_receiver_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       pio_word,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       status_word
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              in_tog, in_last, in_clr;
  logic [DATA_W-1:0] in_data;
  logic              tog_q, clr_q, primed, ack_q, ovf_q;
  logic              evt, pop, accept, clr_rise;
  logic [LVL_W-1:0]  level;
  logic              unused_bits;

  assign unused_bits = ^pio_word[28:DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_tog  <= 1'b0;
      in_last <= 1'b0;
      in_clr  <= 1'b0;
      in_data <= '0;
    end else begin
      in_tog  <= pio_word[PIO_TOG_BIT];
      in_last <= pio_word[PIO_LAST_BIT];
      in_clr  <= pio_word[PIO_OVFCLR_BIT];
      in_data <= pio_word[DATA_W-1:0];
    end
  end

  assign evt      = primed & (in_tog ^ tog_q);
  assign clr_rise = primed & in_clr & ~clr_q;
  assign pop      = m_valid & m_ready;
  assign accept   = evt & ((level != LVL_W'(DEPTH)) | pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tog_q  <= 1'b0;
      clr_q  <= 1'b0;
      primed <= 1'b0;
      ack_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (!primed) begin
      // Prime from the word in_q loads on this same edge, so a toggle already
      // pending when reset releases becomes the reference rather than an event.
      tog_q  <= pio_word[PIO_TOG_BIT];
      clr_q  <= pio_word[PIO_OVFCLR_BIT];
      primed <= 1'b1;
    end else begin
      clr_q <= in_clr;
      if (evt) begin
        tog_q <= in_tog;
        ack_q <= in_tog;
      end
      if (evt && !accept) ovf_q <= 1'b1;
      else if (clr_rise)  ovf_q <= 1'b0;
    end
  end

  hps_rx_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (accept),
    .wdata     ({in_last, in_data}),
    .pop       (pop),
    .rdata     ({m_last, m_data}),
    .level     (level),
    .not_empty (m_valid)
  );

  always_comb begin
    status_word = '0;
    status_word[ST_ACK_BIT]   = ack_q;
    status_word[ST_OVF_BIT]   = ovf_q;
    status_word[ST_VALID_BIT] = m_valid;
    status_word[ST_LEVEL_LSB +: ST_LEVEL_W] = ST_LEVEL_W'(level);
  end
endmodule

// File: tb/tb_hps_pio_word_receiver.sv
// Randomised bench for hps_pio_word_receiver against a queue-based model of
// the software-visible write/ack/overflow/stream behaviour.
module tb_hps_pio_word_receiver;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 16;

  logic              clk, reset_n, m_ready, m_last, m_valid;
  logic [31:0]       pio_word, status_word;
  logic [DATA_W-1:0] m_data;

  hps_pio_word_receiver #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .pio_word(pio_word),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .status_word(status_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit evt; bit clr; logic [31:0] w; } ev_t;

  int n_chk = 0, n_pass = 0;
  logic [DATA_W:0] q[$];
  bit              ack_m, ovf_m, unprimed, ref_tog, prev29;
  ev_t             cur;
  logic [31:0]     cur_pio;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_outputs();
    logic [31:0] st;
    st = {ack_m, ovf_m, q.size() != 0, 21'b0, 8'(q.size())};
    chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("m_data", 32'(m_data), 32'(q[0][DATA_W-1:0]));
      chk("m_last", 32'(m_last), 32'(q[0][DATA_W]));
    end
    chk("status", status_word, st);
  endtask

  // Drive one cycle; a write seen on pio_word takes effect two edges later.
  task automatic step(input logic [31:0] w, input bit r);
    bit pop_m, acc;
    ev_t nxt;
    pio_word = w;
    m_ready  = r;
    pop_m = (q.size() != 0) && r;
    acc   = (q.size() < DEPTH) || pop_m;
    if (pop_m) void'(q.pop_front());
    if (cur.evt) begin
      if (acc) q.push_back({cur.w[30], cur.w[DATA_W-1:0]});
      else     ovf_m = 1'b1;
      ack_m = cur.w[31];
    end
    if (cur.clr && !(cur.evt && !acc)) ovf_m = 1'b0;
    nxt = '{evt: 1'b0, clr: 1'b0, w: w};
    if (unprimed) begin
      unprimed = 1'b0;
    end else begin
      nxt.evt = (w[31] != ref_tog);
      nxt.clr = w[29] && !prev29;
    end
    ref_tog = w[31];
    prev29  = w[29];
    cur = nxt;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input bit r);
    step(cur_pio, r);
  endtask

  task automatic write(input logic [23:0] pl, input bit last, input bit clr, input bit r);
    cur_pio[31]    = ~cur_pio[31];
    cur_pio[30]    = last;
    cur_pio[29]    = clr;
    cur_pio[28:24] = 5'($urandom);
    cur_pio[23:0]  = pl;
    step(cur_pio, r);
  endtask

  task automatic set_clr(input bit b);
    cur_pio[29] = b;
    step(cur_pio, 1'b0);
  endtask

  task automatic model_reset();
    q.delete();
    ack_m = 0; ovf_m = 0; unprimed = 1;
    cur = '{evt: 1'b0, clr: 1'b0, w: 32'h0};
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", 32'(m_valid), 32'h0);
    chk("rst_status", status_word, 32'h0);
    chk("rst_data", 32'({m_last, m_data}), 32'h0);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    reset_n  = 1'b0;
    m_ready  = 1'b0;
    cur_pio  = 32'h8000_0000;
    pio_word = cur_pio;
    repeat (3) @(negedge clk);
    chk("reset_status", status_word, 32'h0);
    chk("reset_valid", 32'(m_valid), 32'h0);
    chk("reset_data", 32'({m_last, m_data}), 32'h0);
    reset_n = 1'b1;

    // Toggle held through reset must not push; then a clean 0x0 write
    repeat (3) idle(0);
    cur_pio = 32'h8000_0000;
    write(24'h0, 0, 0, 0);
    cur_pio = 32'h0; pio_word = cur_pio;
    repeat (2) idle(0);
    repeat (2) idle(1);

    write(24'h1234, 1, 0, 0);
    repeat (2) idle(0);
    repeat (2) idle(1);

    // Overflow on the 17th word, then drain
    for (int i = 1; i <= 17; i++) write(24'(i), 0, 0, 0);
    repeat (2) idle(0);
    repeat (20) idle(1);

    // Clear overflow via rising edge on bit 29
    set_clr(1); set_clr(0); repeat (2) idle(0);

    // Full FIFO with a pop on the push edge: word accepted
    for (int i = 1; i <= 16; i++) write(24'(i), 0, 0, 0);
    repeat (2) idle(0);
    write(24'd17, 1, 0, 0);
    idle(1);
    repeat (20) idle(1);

    // Clear rising together with a dropped push: overflow stays set
    for (int i = 1; i <= 17; i++) write(24'(i), 0, 0, 0);
    repeat (2) idle(0);
    write(24'd18, 0, 1, 0);
    repeat (2) idle(0);
    set_clr(0); set_clr(1); repeat (2) idle(0);
    repeat (20) idle(1);

    // Asynchronous reset with five words queued
    for (int i = 1; i <= 5; i++) write(24'(i + 32), 0, 0, 0);
    repeat (2) idle(0);
    async_reset();
    repeat (3) idle(0);
    write(24'h00abcd, 1, 0, 0);
    repeat (3) idle(0);
    repeat (2) idle(1);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      int op;
      op = $urandom_range(0, 99);
      if (op < 45) begin
        write(24'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) == 0));
      end else if (op < 55) begin
        cur_pio[23:0] = 24'($urandom);
        cur_pio[28:24] = 5'($urandom);
        step(cur_pio, 1'($urandom));
      end else if (op < 60) begin
        set_clr(~cur_pio[29]);
      end else if (op == 60) begin
        async_reset();
        idle(0);
      end else begin
        idle(1'($urandom_range(0, 3) != 0));
      end
    end
    repeat (20) idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
